traffic_generator_burst: RTL
============================

Name: traffic_generator_burst

Overview:
- Parametrised successor to the single-word alternating DDR3 traffic generator. Runs in the UberDDR3 ui clock domain, between the camera write AXI-Stream, the memory request interface, and the HDMI read AXI-Stream.
- Arbitrates read and write commands in bursts of up to BURST_LEN commands per grant, instead of alternating every cycle.
- Supports per-frame base addresses for double buffering and caps the number of outstanding reads.
- Tracks issued commands in an internal tag FIFO so that each response carries its address, read/write type and TLAST.

Parameters:
- DATA_W, 128: memory word and stream data width.
- ADDR_W, 24: memory address width.
- FRAME_WORDS, 115200: words per frame; offsets wrap at FRAME_WORDS-1.
- BURST_LEN, 8: maximum commands issued per grant before arbitration is re-evaluated.
- TAG_DEPTH, 64: depth of the in-flight command FIFO (power of two).
- MAX_RD_OUTSTANDING, 32: maximum reads issued but not yet completed (≤ TAG_DEPTH).

Ports:
- clk  in  1  memory ui clock
- rst_n  in  1  asynchronous active-low reset
- wr_base  in  ADDR_W  write frame base address; sampled on the first write handshake of each frame
- rd_base  in  ADDR_W  read frame base address; sampled on the first read issue of each frame
- memrequest_addr  out  ADDR_W  command address
- memrequest_en  out  1  command strobe
- memrequest_write_enable  out  1  1 = write command
- memrequest_write_data  out  DATA_W  write data
- memrequest_resp_data  in  DATA_W  read response data
- memrequest_complete  in  1  one pulse per completed command (reads and writes), in issue order
- memrequest_busy  in  1  controller cannot accept a command this cycle
- write_axis_data  in  DATA_W  camera write data
- write_axis_tlast  in  1  last word of the camera frame
- write_axis_valid  in  1  camera write data valid
- write_axis_ready  out  1  write handshake ready
- read_axis_data  out  DATA_W  HDMI read data
- read_axis_tlast  out  1  last word of the HDMI frame
- read_axis_valid  out  1  HDMI read data valid
- read_axis_af  in  1  downstream FIFO almost full
- wr_frame_done  out  1  one-cycle pulse on the write TLAST handshake
- tag_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n low, asynchronous): state=INIT; write and read offsets=0; tag FIFO empty; burst counter=0; outstanding-read count=0; latched bases=0; tag_err=0. All outputs are 0. The block is fully functional from the first clk edge after rst_n deasserts.
- Issue conditions:
  - Command slot free: cmd_ok = !memrequest_busy && !tag_full.
  - Write may issue: wr_go = (state==WR) && cmd_ok && write_axis_valid.
  - Read may issue: rd_go = (state==RD) && cmd_ok && !read_axis_af && rd_out < MAX_RD_OUTSTANDING.
- Combinational outputs:
  - write_axis_ready = (state==WR) && cmd_ok.
  - memrequest_en = wr_go || rd_go; memrequest_write_enable = wr_go.
  - memrequest_addr = latched base + offset. At offset 0 the live wr_base/rd_base port value is used instead of the latch.
  - memrequest_write_data = write_axis_data when wr_go, else 0.
- Address arithmetic:
  - Address = base + offset, computed modulo 2^ADDR_W.
  - Offsets increment on each issue and wrap FRAME_WORDS-1 → 0.
  - Write offset additionally resets to 0 on a handshake with write_axis_tlast=1, even mid-frame. wr_frame_done pulses in that same cycle.
- State machine (INIT, RD, WR):
  - INIT → RD after one cycle.
  - In RD or WR, the burst counter increments on each issue.
  - Switch to the other state when either:
    - the burst counter reaches BURST_LEN-1 on an issue, or
    - the current direction cannot issue this cycle and the other direction has a request pending. Write is pending when write_axis_valid=1. Read is pending when !read_axis_af and rd_out < MAX_RD_OUTSTANDING.
  - The burst counter clears on every switch.
  - With no pending work in either direction, the FSM stays in its current state.
- Tag FIFO:
  - Entries are {addr, we, last}, where last = (read offset == FRAME_WORDS-1).
  - Push on memrequest_en; pop on memrequest_complete.
  - A push and a pop in the same cycle are both legal, including when the FIFO is full.
  - memrequest_complete while empty: tag_err sets, the FIFO is unchanged, and no output is produced.
- Outstanding reads (rd_out):
  - +1 on rd_go, -1 on complete of a read entry; both in the same cycle leaves it unchanged.
- Read output:
  - read_axis_valid = memrequest_complete && head.we==0 && !empty.
  - read_axis_data = memrequest_resp_data; read_axis_tlast = head.last.
  - Zero added latency. Write completions pop the FIFO silently.
- Backpressure:
  - read_axis_ready does not exist. Downstream capacity is guaranteed through read_axis_af together with MAX_RD_OUTSTANDING.

Test Plan:
- Reset mid-burst (rst_n pulsed low between edges) → all outputs 0 immediately; the next frame's first read goes to rd_base+0.
- Write-only traffic, wr_base=0x1000, FRAME_WORDS=16, 20 words with tlast on word 15:
  - addresses 0x1000–0x100F, then 0x1000–0x1003;
  - wr_frame_done pulses once.
- Both streams saturated, BURST_LEN=4 → exactly 4 reads then 4 writes, repeating; 0 idle cycles while busy=0.
- Read-only traffic, completions withheld → exactly MAX_RD_OUTSTANDING=32 reads issued, then the FSM switches to WR only if write_axis_valid=1; issue resumes after the first completion.
- Read-only traffic, FRAME_WORDS=16 → read_axis_tlast=1 only on the response for offset 15; the next read issued goes to offset 0 with a freshly sampled rd_base.
- Inject memrequest_complete with the FIFO empty → tag_err=1 and stays 1; read_axis_valid stays 0.

Source files
------------

// File: rtl/traffic_generator_burst_if.sv
// ---------------------------------------------------------------------------
// traffic_generator_burst_if
//   Bundles the three bus-facing groups of the burst traffic generator:
//   - memory request interface (command out, completion/response in)
//   - camera write AXI-Stream (data/tlast/valid in, ready out)
//   - HDMI read AXI-Stream (data/tlast/valid out, almost-full in)
//   master : the traffic generator side
//   slave  : the memory controller / stream endpoints side
// ---------------------------------------------------------------------------
interface traffic_generator_burst_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 24
);
    // memory request interface
    logic [ADDR_W-1:0] memrequest_addr;
    logic              memrequest_en;
    logic              memrequest_write_enable;
    logic [DATA_W-1:0] memrequest_write_data;
    logic [DATA_W-1:0] memrequest_resp_data;
    logic              memrequest_complete;
    logic              memrequest_busy;

    // camera write stream
    logic [DATA_W-1:0] write_axis_data;
    logic              write_axis_tlast;
    logic              write_axis_valid;
    logic              write_axis_ready;

    // HDMI read stream
    logic [DATA_W-1:0] read_axis_data;
    logic              read_axis_tlast;
    logic              read_axis_valid;
    logic              read_axis_af;

    modport master (
        output memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
        input  memrequest_resp_data, memrequest_complete, memrequest_busy,
        input  write_axis_data, write_axis_tlast, write_axis_valid,
        output write_axis_ready,
        output read_axis_data, read_axis_tlast, read_axis_valid,
        input  read_axis_af
    );

    modport slave (
        input  memrequest_addr, memrequest_en, memrequest_write_enable, memrequest_write_data,
        output memrequest_resp_data, memrequest_complete, memrequest_busy,
        output write_axis_data, write_axis_tlast, write_axis_valid,
        input  write_axis_ready,
        input  read_axis_data, read_axis_tlast, read_axis_valid,
        output read_axis_af
    );
endinterface

// File: rtl/traffic_generator_burst.sv
// ---------------------------------------------------------------------------
// traffic_generator_burst
//   Burst-arbitrated DDR3 traffic generator in the memory ui clock domain.
//   Moves camera frames into memory and reads display frames back out,
//   granting up to BURST_LEN commands per direction before re-arbitrating.
//   Every issued command is tagged in an in-order FIFO so that completions
//   can be routed (reads to the HDMI stream with TLAST, writes dropped).
//
// Ports:
//   clk, rst_n      memory ui clock, asynchronous active-low reset
//   wr_base         write frame base, latched on the first write of a frame
//   rd_base         read frame base, latched on the first read of a frame
//   bus             memory request + write stream + read stream (master)
//   wr_frame_done   one-cycle pulse on the write TLAST handshake
//   tag_err         sticky: completion arrived with no command in flight
// ---------------------------------------------------------------------------
module traffic_generator_burst #(
    parameter int DATA_W             = 128,
    parameter int ADDR_W             = 24,
    parameter int FRAME_WORDS        = 115200,
    parameter int BURST_LEN          = 8,
    parameter int TAG_DEPTH          = 64,
    parameter int MAX_RD_OUTSTANDING = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          wr_base,
    input  logic [ADDR_W-1:0]          rd_base,
    traffic_generator_burst_if.master  bus,
    output logic                       wr_frame_done,
    output logic                       tag_err
);

    localparam int OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int RO_W  = $clog2(MAX_RD_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_INIT, S_RD, S_WR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              last;
    } tag_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   burst_q;
    logic [OFF_W-1:0]  wr_off_q, rd_off_q;
    logic [ADDR_W-1:0] wr_base_q, rd_base_q;
    tag_t              tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W:0]    cnt_q;
    logic [RO_W-1:0]   rd_out_q;
    logic              tag_err_q;

    logic              tag_full, tag_empty, cmd_ok;
    logic              wr_pend, rd_pend, wr_go, rd_go;
    logic              push, pop, rd_resp, burst_end;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign tag_full  = (cnt_q == (PTR_W+1)'(TAG_DEPTH));
    assign tag_empty = (cnt_q == '0);
    assign cmd_ok    = !bus.memrequest_busy && !tag_full;
    assign wr_pend   = bus.write_axis_valid;
    assign rd_pend   = !bus.read_axis_af && (rd_out_q < RO_W'(MAX_RD_OUTSTANDING));
    assign burst_end = (burst_q == BC_W'(BURST_LEN - 1));

    // Offset 0 is the first word of a frame: the latch is not loaded yet,
    // so the live base port supplies the address for that word.
    assign wr_addr = ((wr_off_q == '0) ? wr_base : wr_base_q) + ADDR_W'(wr_off_q);
    assign rd_addr = ((rd_off_q == '0) ? rd_base : rd_base_q) + ADDR_W'(rd_off_q);

    assign push    = wr_go || rd_go;
    assign pop     = bus.memrequest_complete && !tag_empty;
    assign rd_resp = pop && !tag_mem[rptr_q].we;
    assign tag_err = tag_err_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // A grant ends when the burst is used up, or when this direction is
    // stalled while the other one has work waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = S_RD;
            S_RD:   if ((rd_go && burst_end) || (!rd_go && wr_pend)) state_d = S_WR;
            S_WR:   if ((wr_go && burst_end) || (!wr_go && rd_pend)) state_d = S_RD;
            default: state_d = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_go = (state_q == S_WR) && cmd_ok && bus.write_axis_valid;
        rd_go = (state_q == S_RD) && cmd_ok && rd_pend;

        bus.write_axis_ready        = (state_q == S_WR) && cmd_ok;
        bus.memrequest_en           = wr_go || rd_go;
        bus.memrequest_write_enable = wr_go;
        bus.memrequest_addr         = '0;
        if (wr_go)      bus.memrequest_addr = wr_addr;
        else if (rd_go) bus.memrequest_addr = rd_addr;
        bus.memrequest_write_data   = wr_go ? bus.write_axis_data : '0;

        // Read responses leave with zero latency; gated so idle outputs stay 0.
        bus.read_axis_valid = rd_resp;
        bus.read_axis_data  = rd_resp ? bus.memrequest_resp_data : '0;
        bus.read_axis_tlast = rd_resp && tag_mem[rptr_q].last;

        wr_frame_done = wr_go && bus.write_axis_tlast;
    end

    // ---------------- burst counter, offsets and base latches ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q   <= '0;
            wr_off_q  <= '0;
            rd_off_q  <= '0;
            wr_base_q <= '0;
            rd_base_q <= '0;
        end else begin
            if (state_q != state_d) burst_q <= '0;
            else if (push)          burst_q <= burst_q + 1'b1;

            if (wr_go) begin
                if (wr_off_q == '0) wr_base_q <= wr_base;
                // TLAST realigns the write frame even if it arrives early.
                if (bus.write_axis_tlast || wr_off_q == OFF_W'(FRAME_WORDS - 1))
                    wr_off_q <= '0;
                else
                    wr_off_q <= wr_off_q + 1'b1;
            end

            if (rd_go) begin
                if (rd_off_q == '0) rd_base_q <= rd_base;
                if (rd_off_q == OFF_W'(FRAME_WORDS - 1)) rd_off_q <= '0;
                else                                      rd_off_q <= rd_off_q + 1'b1;
            end
        end
    end

    // ---------------- tag FIFO storage ----------------
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wptr_q] <= '{addr: bus.memrequest_addr,
                                 we:   wr_go,
                                 last: (rd_off_q == OFF_W'(FRAME_WORDS - 1))};
    end

    // ---------------- tag FIFO control, read credit, error flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rd_out_q  <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;

            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            case ({rd_go, rd_resp})
                2'b10:   rd_out_q <= rd_out_q + 1'b1;
                2'b01:   rd_out_q <= rd_out_q - 1'b1;
                default: rd_out_q <= rd_out_q;
            endcase

            if (bus.memrequest_complete && tag_empty) tag_err_q <= 1'b1;
        end
    end

endmodule
